// File: rtl/jvm_pkg.sv
// jvm_pkg: shared widths, opcodes, FSM states and ROM entry type for the micro-op sequencer
package jvm_pkg;
    localparam int BYTE     = 8;
    localparam int INSTR_W  = 2 * BYTE;
    localparam int UOP_W    = 4 * BYTE;
    localparam int ADDR_W   = 16;
    localparam int MAX_UOPS = 4;
    localparam int IDX_W    = $clog2(MAX_UOPS) + 1;

    localparam logic [BYTE-1:0] OP_ICONST_0 = 8'h03;
    localparam logic [BYTE-1:0] OP_LCONST_1 = 8'h0A;
    localparam logic [BYTE-1:0] OP_DLOAD    = 8'h18;
    localparam logic [BYTE-1:0] OP_DLOAD_0  = 8'h26;
    localparam logic [BYTE-1:0] OP_DLOAD_3  = 8'h29;
    localparam logic [BYTE-1:0] OP_IALOAD   = 8'h2E;
    localparam logic [BYTE-1:0] OP_LALOAD   = 8'h2F;
    localparam logic [BYTE-1:0] OP_IASTORE  = 8'h4F;
    localparam logic [BYTE-1:0] OP_LASTORE  = 8'h50;
    localparam logic [BYTE-1:0] OP_IADD     = 8'h60;
    localparam logic [BYTE-1:0] OP_LADD     = 8'h61;
    localparam logic [BYTE-1:0] OP_DMUL     = 8'h6B;
    localparam logic [BYTE-1:0] OP_DDIV     = 8'h6F;
    localparam logic [BYTE-1:0] OP_IREM     = 8'h70;
    localparam logic [BYTE-1:0] OP_DREM     = 8'h73;
    localparam logic [BYTE-1:0] OP_DNEG     = 8'h77;
    localparam logic [BYTE-1:0] OP_ISHL     = 8'h78;
    localparam logic [BYTE-1:0] OP_IAND     = 8'h7E;
    localparam logic [BYTE-1:0] OP_IOR      = 8'h80;
    localparam logic [BYTE-1:0] OP_I2L      = 8'h85;
    localparam logic [BYTE-1:0] OP_L2D      = 8'h8A;
    localparam logic [BYTE-1:0] OP_I2B      = 8'h91;
    localparam logic [BYTE-1:0] OP_LCMP     = 8'h94;
    localparam logic [BYTE-1:0] OP_IRETURN  = 8'hAC;
    localparam logic [BYTE-1:0] OP_DRETURN  = 8'hAF;

    localparam logic [UOP_W-1:0] UOP_BASIC   = 32'h920104E0;
    localparam logic [UOP_W-1:0] UOP_DLOAD_0 = 32'h920104E7;
    localparam logic [UOP_W-1:0] UOP_DLOAD_1 = 32'h920104E6;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    typedef struct packed {
        logic             legal;
        logic [IDX_W-1:0] count;
        logic             subst;
        logic [UOP_W-1:0] uop;
    } rom_entry_t;
endpackage

// File: rtl/uop_rom.sv
// uop_rom: combinational micro-op table lookup
//   opcode : instruction opcode byte
//   index  : micro-op position within the sequence
//   entry  : {legal, count, subst, uop}; all zero for unknown opcodes
module uop_rom
    import jvm_pkg::*;
(
    input  logic [BYTE-1:0]  opcode,
    input  logic [IDX_W-1:0] index,
    output rom_entry_t       entry
);
    always_comb begin
        entry = '0;
        case (opcode) inside
            OP_DLOAD: begin
                entry.legal = 1'b1;
                entry.count = IDX_W'(2);
                entry.subst = index == '0;
                entry.uop   = index == '0 ? UOP_DLOAD_0 : index == IDX_W'(1) ? UOP_DLOAD_1 : '0;
            end
            [OP_ICONST_0:OP_LCONST_1], [OP_DLOAD_0:OP_DLOAD_3], OP_IALOAD, OP_LALOAD,
            OP_IASTORE, OP_LASTORE, OP_IADD, OP_LADD, OP_DMUL, OP_DDIV, OP_IREM, OP_DREM,
            OP_DNEG, OP_ISHL, [OP_IAND:OP_IOR], [OP_I2L:OP_L2D], [OP_I2B:OP_LCMP],
            OP_IRETURN, OP_DRETURN: begin
                entry.legal = 1'b1;
                entry.count = IDX_W'(1);
                entry.uop   = index == '0 ? UOP_BASIC : '0;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/jvm_uop_sequencer.sv
// jvm_uop_sequencer: issues the micro-op sequence of one JVM instruction over a valid/ack handshake
//   clk, reset          : clock, synchronous active-high reset
//   start, ready        : request to decode instruction_in / block idle and accepting
//   instruction_in      : [7:0] opcode, [15:8] operand; addr_base: first micro-op address
//   uop_out, uop_valid  : current micro-op and its valid; uop_ack: memory accepts it
//   address_for_memory  : address of the current micro-op
//   done, illegal       : one-cycle completion pulse / unknown-opcode flag alongside done
module jvm_uop_sequencer
    import jvm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               ready,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic [ADDR_W-1:0]  addr_base,
    output logic [UOP_W-1:0]   uop_out,
    output logic               uop_valid,
    input  logic               uop_ack,
    output logic [ADDR_W-1:0]  address_for_memory,
    output logic               done,
    output logic               illegal
);
    state_t           state, state_nx;
    rom_entry_t       entry;
    logic [BYTE-1:0]  opcode_q, operand_q, opcode_sel, operand_sel;
    logic [IDX_W-1:0] index, index_nx, index_sel, count_q;
    logic [UOP_W-1:0] uop_word;
    logic             illegal_q, accept, step, legal, last;

    // In IDLE the ROM looks at the incoming instruction so the first micro-op
    // can be registered on the accept edge; in ISSUE it pre-fetches index+1.
    assign accept      = state == IDLE && start;
    assign step        = state == ISSUE && uop_ack;
    assign index_nx    = index + IDX_W'(1);
    assign opcode_sel  = state == IDLE ? instruction_in[BYTE-1:0] : opcode_q;
    assign operand_sel = state == IDLE ? instruction_in[INSTR_W-1:BYTE] : operand_q;
    assign index_sel   = state == IDLE ? '0 : index_nx;
    assign legal       = entry.legal && entry.count != '0 && entry.count <= IDX_W'(MAX_UOPS);
    assign last        = index_nx == count_q;
    assign uop_word    = entry.subst ? {entry.uop[UOP_W-1:BYTE], operand_sel} : entry.uop;

    uop_rom u_rom (
        .opcode (opcode_sel),
        .index  (index_sel),
        .entry  (entry)
    );

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (legal ? ISSUE : DONE) : IDLE;
            ISSUE:   state_nx = step && last ? DONE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready     = state == IDLE;
        uop_valid = state == ISSUE;
        done      = state == DONE;
        illegal   = state == DONE && illegal_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q           <= '0;
            operand_q          <= '0;
            count_q            <= '0;
            index              <= '0;
            illegal_q          <= 1'b0;
            uop_out            <= '0;
            address_for_memory <= '0;
        end else if (accept) begin
            opcode_q           <= opcode_sel;
            operand_q          <= operand_sel;
            count_q            <= entry.count;
            index              <= '0;
            illegal_q          <= !legal;
            uop_out            <= uop_word;
            address_for_memory <= addr_base;
        end else if (step) begin
            index              <= index_nx;
            uop_out            <= uop_word;
            address_for_memory <= address_for_memory + ADDR_W'(1);
        end
    end
endmodule
